// File: rtl/ysyx_23060111_mem_arbiter.sv
// Two-requester memory arbiter: shares one memory port between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
//
// Handshake flow: IDLE accepts one request (valid/ready), ISSUE presents the
// registered request to memory until mem_req_ready, WAIT waits for
// mem_resp_valid or returns an error response after TIMEOUT cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   ifu_req_* / ifu_resp_*   IFU read request and 1-cycle response strobe
//   lsu_req_* / lsu_resp_*   LSU read/write request and 1-cycle response strobe
//   resp_err                 qualifies the active resp_valid; 1 = timeout
//   mem_req_* / mem_*        registered request to memory
//   mem_resp_valid/mem_rdata memory response
//   busy                     high whenever the state is not IDLE
//
// Configuration macro: YSYX_23060111_ARB_RR_EN
//   defined   -> round-robin arbitration on simultaneous requests
//   undefined -> fixed priority, LSU wins ties

module ysyx_23060111_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,

    output logic            resp_err,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,

    output logic            busy
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            wen_q,   wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic            grant_lsu;

`ifdef YSYX_23060111_ARB_RR_EN
    logic            last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time is granted.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));

    // Last-grant register; resets to LSU so the first tie goes to the IFU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= OWN_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: any LSU request wins.
    assign grant_lsu = lsu_req_valid;
`endif

    // State and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Next-state, request capture and response routing.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
`ifdef YSYX_23060111_ARB_RR_EN
        last_grant_d   = last_grant_q;
`endif
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        resp_err       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Ready is held low while reset is asserted, even though the
                // state register already reads IDLE.
                if (rst) begin
                    if (grant_lsu) begin
                        lsu_req_ready = 1'b1;
                        owner_d       = OWN_LSU;
                        addr_d        = lsu_addr;
                        wen_d         = lsu_wen;
                        wdata_d       = lsu_wdata;
                        wmask_d       = lsu_wmask;
                        state_d       = S_ISSUE;
`ifdef YSYX_23060111_ARB_RR_EN
                        last_grant_d  = OWN_LSU;
`endif
                    end else if (ifu_req_valid) begin
                        ifu_req_ready = 1'b1;
                        owner_d       = OWN_IFU;
                        addr_d        = ifu_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wmask_d       = '1;
                        state_d       = S_ISSUE;
`ifdef YSYX_23060111_ARB_RR_EN
                        last_grant_d  = OWN_IFU;
`endif
                    end
                end
            end

            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A real response beats a timeout landing in the same cycle.
                if (mem_resp_valid) begin
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                        lsu_rdata      = mem_rdata;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = mem_rdata;
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                    end else begin
                        ifu_resp_valid = 1'b1;
                    end
                    resp_err = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory request fields come straight from the registers.
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Directed self-checking bench for ysyx_23060111_mem_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.

module tb_ysyx_23060111_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic          clk;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          resp_err;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    ysyx_23060111_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic test_reset();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        mid();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b exp 00", {ifu_req_ready, lsu_req_ready}); end
        checks++; if ({ifu_resp_valid, lsu_resp_valid, resp_err, mem_req_valid} !== 4'b0000) begin failures++; $display("FAIL reset_valids: got %b exp 0000", {ifu_resp_valid, lsu_resp_valid, resp_err, mem_req_valid}); end
        checks++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin failures++; $display("FAIL reset_mem_regs: got %h/%b/%h/%h exp all 0", mem_addr, mem_wen, mem_wdata, mem_wmask); end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_arbitration();
        logic [2:0] exp_lsu;
`ifdef YSYX_23060111_ARB_RR_EN
        exp_lsu = 3'b010;   // IFU, LSU, IFU
`else
        exp_lsu = 3'b111;   // LSU, LSU, LSU
`endif
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_1000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_2000;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            mid();
            checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu[r], ~exp_lsu[r]}) begin failures++; $display("FAIL arb_grant_%0d: got lsu/ifu ready %b exp %b", r, {lsu_req_ready, ifu_req_ready}, {exp_lsu[r], ~exp_lsu[r]}); end
            tick();
            mid();
            checks++; if (mem_addr !== (exp_lsu[r] ? 32'h0000_2000 : 32'h0000_1000) || mem_req_valid !== 1'b1) begin failures++; $display("FAIL arb_issue_%0d: got addr %h valid %b", r, mem_addr, mem_req_valid); end
            tick();
            mem_resp_valid = 1'b1;
            mem_rdata      = DW'(r + 1);
            mid();
            checks++; if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu[r], ~exp_lsu[r]}) begin failures++; $display("FAIL arb_resp_%0d: got lsu/ifu resp %b exp %b", r, {lsu_resp_valid, ifu_resp_valid}, {exp_lsu[r], ~exp_lsu[r]}); end
            tick();
            mem_resp_valid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lsu_write();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0040;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'b0011;
        mid();
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin failures++; $display("FAIL wr_accept: got %b exp 10", {lsu_req_ready, ifu_req_ready}); end
        tick();
        lsu_req_valid = 1'b0;
        lsu_wdata     = '0;
        mem_req_ready = 1'b1;
        mid();
        checks++; if ({mem_req_valid, mem_wen, mem_wdata, mem_wmask, mem_addr} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h8000_0040}) begin failures++; $display("FAIL wr_issue: got v%b w%b %h %b %h", mem_req_valid, mem_wen, mem_wdata, mem_wmask, mem_addr); end
        tick();
        mem_req_ready = 1'b0;
        mid();
        checks++; if ({lsu_resp_valid, ifu_resp_valid, mem_req_valid, busy} !== 4'b0001) begin failures++; $display("FAIL wr_wait: got %b exp 0001", {lsu_resp_valid, ifu_resp_valid, mem_req_valid, busy}); end
        tick();
        mem_resp_valid = 1'b1;
        mid();
        checks++; if ({lsu_resp_valid, ifu_resp_valid, resp_err} !== 3'b100) begin failures++; $display("FAIL wr_resp: got %b exp 100", {lsu_resp_valid, ifu_resp_valid, resp_err}); end
        tick();
        mem_resp_valid = 1'b0;
        mid();
        checks++; if ({busy, mem_wen, mem_wdata} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_hold: got busy %b wen %b data %h", busy, mem_wen, mem_wdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        mid();
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin failures++; $display("FAIL rd_accept: got %b exp 10", {ifu_req_ready, lsu_req_ready}); end
        tick();
        ifu_req_valid = 1'b0;
        mid();
        checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'hF}) begin failures++; $display("FAIL rd_issue: got v%b %h w%b m%h", mem_req_valid, mem_addr, mem_wen, mem_wmask); end
        checks++; if ({ifu_req_ready, busy} !== 2'b01) begin failures++; $display("FAIL rd_issue_ready: got %b exp 01", {ifu_req_ready, busy}); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_9117;
        mid();
        checks++; if ({ifu_resp_valid, ifu_rdata, resp_err, lsu_resp_valid} !== {1'b1, 32'h0000_9117, 1'b0, 1'b0}) begin failures++; $display("FAIL rd_resp: got v%b %h e%b lsu%b", ifu_resp_valid, ifu_rdata, resp_err, lsu_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        mid();
        checks++; if ({busy, ifu_resp_valid, ifu_rdata} !== 34'h0) begin failures++; $display("FAIL rd_done: got busy %b v%b %h", busy, ifu_resp_valid, ifu_rdata); end
        clear_inputs();
        tick();
    endtask

    // race=0: memory never answers; race=1: answer lands on the timeout cycle.
    task automatic test_timeout(input bit race);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0300;
        lsu_wen       = 1'b0;
        mem_rdata     = 32'hA5A5_A5A5;
        mid();
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL to_accept_%0d: got %b exp 1", race, lsu_req_ready); end
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (race && i == 15) mem_resp_valid = 1'b1;
            mid();
            if (i < 15) begin
                checks++; if ({lsu_resp_valid, ifu_resp_valid, busy} !== 3'b001) begin failures++; $display("FAIL to_wait_%0d_%0d: got %b exp 001", race, i, {lsu_resp_valid, ifu_resp_valid, busy}); end
            end else if (race) begin
                checks++; if ({lsu_resp_valid, resp_err, lsu_rdata} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin failures++; $display("FAIL to_race: got v%b e%b %h exp v1 e0 a5a5a5a5", lsu_resp_valid, resp_err, lsu_rdata); end
            end else begin
                checks++; if ({lsu_resp_valid, resp_err, lsu_rdata, ifu_resp_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin failures++; $display("FAIL to_expire: got v%b e%b %h ifu%b exp v1 e1 0 ifu0", lsu_resp_valid, resp_err, lsu_rdata, ifu_resp_valid); end
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        if (!race) begin
            tick();
            tick();
            mem_resp_valid = 1'b1;
            mid();
            checks++; if ({lsu_resp_valid, ifu_resp_valid, resp_err, busy} !== 4'b0000) begin failures++; $display("FAIL to_late_resp: got %b exp 0000", {lsu_resp_valid, ifu_resp_valid, resp_err, busy}); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0200;
        mid();
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL st_accept: got %b exp 1", ifu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        for (int i = 0; i < 40; i++) begin
            mid();
            checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, busy, ifu_resp_valid, resp_err} !== {1'b1, 32'h8000_0200, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL st_hold_%0d: got v%b %h w%b m%h b%b r%b e%b", i, mem_req_valid, mem_addr, mem_wen, mem_wmask, busy, ifu_resp_valid, resp_err); end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        mid();
        checks++; if ({ifu_resp_valid, ifu_rdata, resp_err} !== {1'b1, 32'h1234_5678, 1'b0}) begin failures++; $display("FAIL st_resp: got v%b %h e%b", ifu_resp_valid, ifu_rdata, resp_err); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_in_wait();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        #1;
        checks++; if ({busy, mem_req_valid, ifu_req_ready, ifu_resp_valid} !== 4'b0000) begin failures++; $display("FAIL rw_async: got %b exp 0000", {busy, mem_req_valid, ifu_req_ready, ifu_resp_valid}); end
        checks++; if ({mem_addr, mem_wmask} !== '0) begin failures++; $display("FAIL rw_async_regs: got %h %h exp 0", mem_addr, mem_wmask); end
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        mid();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            mid();
            checks++; if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin failures++; $display("FAIL rw_no_resp_%0d: got %b exp 000", i, {ifu_resp_valid, lsu_resp_valid, busy}); end
        end
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0104;
        mid();
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL rw_reaccept: got %b exp 1", ifu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0513;
        mid();
        checks++; if ({ifu_resp_valid, ifu_rdata, mem_addr} !== {1'b1, 32'h0000_0513, 32'h8000_0104}) begin failures++; $display("FAIL rw_complete: got v%b %h addr %h", ifu_resp_valid, ifu_rdata, mem_addr); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_arbitration();
        test_lsu_write();
        test_ifu_read();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stall();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060111_mem_arbiter.md
Name: ysyx_23060111_mem_arbiter

Overview:
Two-requester arbiter that shares the single memory port between the instruction fetch unit and the load/store path.
- Accepts one request at a time over a valid/ready handshake and holds it while the memory handshake completes.
- Routes the memory response back to the requester that issued it.
- Bounds every transaction with a response timeout so a missing response cannot stall the core indefinitely.

Parameters:
AW, 32, address width
DW, 32, data width (must be a multiple of 8)
TIMEOUT, 16, number of WAIT-state cycles before an error response is returned (minimum 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  AW  IFU fetch address
ifu_resp_valid  out  1  IFU response strobe, 1 cycle
ifu_rdata  out  DW  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  AW  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DW  write data
lsu_wmask  in  DW/8  byte enables
lsu_resp_valid  out  1  LSU response strobe, 1 cycle
lsu_rdata  out  DW  LSU read data
resp_err  out  1  qualifies the current resp_valid; 1 = timeout
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_addr  out  AW  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DW  registered write data
mem_wmask  out  DW/8  registered byte mask
mem_resp_valid  in  1  memory response strobe
mem_rdata  in  DW  memory read data
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous) forces the following:
  - state = IDLE; owner = IFU; wait counter = 0.
  - All mem_* registers = 0.
  - All valid, ready, resp_err and busy outputs = 0.
  - An in-flight transaction is dropped; no response is issued for it after reset releases.
- FSM state IDLE:
  - The winner's req_ready = 1 combinationally when its req_valid = 1; the loser's req_ready = 0.
  - On acceptance (valid && ready), latch addr, wen, wdata, wmask and owner, then go to ISSUE.
  - IFU requests are latched with wen = 0 and wmask = all ones.
- FSM state ISSUE:
  - mem_req_valid = 1, driven from the registered fields.
  - On mem_req_ready, go to WAIT and clear the counter.
  - There is no timeout in ISSUE.
- FSM state WAIT:
  - The counter increments every cycle.
  - When mem_resp_valid = 1, the owner's resp_valid = 1 in the same cycle. Owner rdata = mem_rdata, resp_err = 0, then go to IDLE.
  - Otherwise, when the counter reaches TIMEOUT-1, the owner's resp_valid = 1 with resp_err = 1 and rdata = 0, then go to IDLE.
  - A response arriving in the same cycle as the timeout wins: resp_err = 0.
- The non-owner's resp_valid is always 0.
- ifu_rdata and lsu_rdata are 0 whenever their resp_valid is 0.
- mem_resp_valid outside WAIT is ignored. This covers late responses after a timeout.
- Both req_ready outputs are 0 in ISSUE and WAIT; only one transaction is outstanding.
- Latency: accept in cycle N, mem_req_valid in N+1. With mem_req_ready in N+1 and mem_resp_valid in N+2, the response appears in N+2. The next acceptance is possible in N+3.
- mem_* registers hold their value after a transaction; they change only on a new acceptance.
- Arbitration with both requesters valid in IDLE: LSU wins (fixed priority).

Optional Feature:
Macro YSYX_23060111_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register is updated on every acceptance.
  - On a tie, the requester not equal to last_grant wins.
  - Reset value of last_grant = LSU, so the first tie grants IFU.
- Undefined: fixed LSU-first priority; no last_grant register exists.
- A single requester is granted immediately in both modes.

Test Plan:
1. IFU-only read: ifu_req_valid=1, ifu_addr=0x80000000. Memory asserts ready immediately and returns 0x00009117 one cycle later. Required: ifu_req_ready in cycle 0, mem_req_valid in cycle 1 with mem_addr=0x80000000, ifu_resp_valid with ifu_rdata=0x00009117 in cycle 2, resp_err=0.
2. LSU write: lsu_addr=0x80000040, lsu_wen=1, lsu_wdata=0xDEADBEEF, lsu_wmask=4'b0011. Required: mem_wen=1, mem_wdata=0xDEADBEEF, mem_wmask=4'b0011 while mem_req_valid; lsu_resp_valid on mem_resp_valid; ifu_resp_valid stays 0.
3. Simultaneous requests, 3 back-to-back pairs:
   - Fixed priority: grants are LSU, LSU, LSU while lsu_req_valid stays high.
   - With YSYX_23060111_ARB_RR_EN: grants are IFU, LSU, IFU.
4. Timeout with TIMEOUT=16: memory accepts but never responds. Required: after 16 WAIT cycles, owner resp_valid=1, resp_err=1, rdata=0. A mem_resp_valid pulse 3 cycles later produces no response strobe.
5. mem_req_ready held 0 for 40 cycles: mem_req_valid and all fields stay stable, no timeout, busy=1; the transaction completes normally once ready=1.
6. rst pulsed low during WAIT: all outputs 0 immediately (asynchronous); no resp_valid after release; the next request is accepted from IDLE.
